// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM debounced input PIO.
// Register map and bus width used by avalon_pio_debounce and its bench.
package pio_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_IRQ_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE_CAP = 2'd2;
  localparam logic [1:0] REG_EDGE_POL = 2'd3;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: two-flop synchroniser followed by an optional stability filter.
// PIO_DEBOUNCE_EN compiles in the counter; otherwise stable follows sync2 one cycle later.
module pio_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic stable_o
);

  logic sync1_q, sync2_q;
  logic stable_q, stable_d;

`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where sync2 agrees with stable restarts the count, so only an
  // uninterrupted mismatch run of DEBOUNCE_CYCLES is accepted.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    stable_d = sync2_q;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/avalon_pio_debounce.sv
// Avalon-MM input PIO: per-channel debounce, polarity-selectable sticky edge capture, masked irq.
// Optional feature macro: PIO_DEBOUNCE_EN (debounce counters compiled in when defined).
module avalon_pio_debounce
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [BUS_W-1:0]  avs_writedata,
  output logic [BUS_W-1:0]  avs_readdata,
  input  logic [WIDTH-1:0]  pio_in,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] wr_bits;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             unused_wr;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pio_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i    (clk_clk),
      .rst_ni   (reset_reset_n),
      .din_i    (pio_in[g]),
      .stable_o (stable[g])
    );
  end

  assign wr_bits   = avs_writedata[WIDTH-1:0];
  assign unused_wr = ^avs_writedata;

  assign edge_hit = (stable & ~stable_dly_q & ~pol_q) |
                    (~stable & stable_dly_q & pol_q);

  // Clear is applied before set so a coincident edge keeps its capture bit;
  // reads sample the pre-write register values.
  always_comb begin
    mask_d  = mask_q;
    pol_d   = pol_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    irq_d   = |(cap_q & mask_q);
    if (avs_write) begin
      unique case (avs_address)
        REG_IRQ_MASK: mask_d = wr_bits;
        REG_EDGE_CAP: cap_d  = cap_q & ~wr_bits;
        REG_EDGE_POL: pol_d  = wr_bits;
        default: ;
      endcase
    end
    cap_d = cap_d | edge_hit;
    if (avs_read) begin
      rdata_d = '0;
      unique case (avs_address)
        REG_DATA:     rdata_d[WIDTH-1:0] = stable;
        REG_IRQ_MASK: rdata_d[WIDTH-1:0] = mask_q;
        REG_EDGE_CAP: rdata_d[WIDTH-1:0] = cap_q;
        REG_EDGE_POL: rdata_d[WIDTH-1:0] = pol_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_dly_q <= '0;
      mask_q       <= '0;
      cap_q        <= '0;
      pol_q        <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable;
      mask_q       <= mask_d;
      cap_q        <= cap_d;
      pol_q        <= pol_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: doc/avalon_pio_debounce.md
# avalon_pio_debounce

Parametrised Avalon-MM input PIO for board keys and switches. It replaces the fixed-width keys/switches PIO instances in the Nios II system. Each channel has a synchroniser, a per-channel debounce filter, programmable edge polarity, sticky edge capture and a masked, registered interrupt.

## Interface
Parameters:
- WIDTH, 18: number of input channels; legal range 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a new level; must be ≥ 2. Counter width is $clog2(DEBOUNCE_CYCLES).

Ports (one clock; reset is asynchronous and active-low):
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  register word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- pio_in  in  WIDTH  raw asynchronous inputs.
- irq  out  1  level interrupt to the CPU.

## Operation
- Registers (bits ≥ WIDTH read as 0; writes to them are ignored):
  - 0 DATA: RO debounced levels; writes ignored.
  - 1 IRQ_MASK: RW.
  - 2 EDGE_CAPTURE: read returns sticky flags; write-1-to-clear.
  - 3 EDGE_POL: RW per bit; 0 = rising, 1 = falling.
- Synchroniser: each channel passes through two flops, sync1 → sync2.
- Debounce, per channel:
  - If sync2 ≠ stable, cnt increments.
  - If cnt = DEBOUNCE_CYCLES−1 and a mismatch is still present, stable ← sync2 and cnt ← 0.
  - If sync2 = stable, cnt ← 0. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- Edge detect: stable_d is stable delayed one cycle. A bit's edge fires when stable & ~stable_d (POL = 0) or ~stable & stable_d (POL = 1).
- EDGE_CAPTURE update: bit ← 1 on edge. A write-1 clears the bit. If an edge and a clear hit the same bit in the same cycle, the set wins.
- irq: registered; irq ← |(EDGE_CAPTURE & IRQ_MASK).
- Reads: readdata is registered on the cycle avs_read is high and holds its value otherwise. A read and a write to the same register in one cycle returns the pre-write value.
- Reset values: all outputs, sync flops, stable, stable_d, counters, IRQ_MASK, EDGE_CAPTURE and EDGE_POL are 0.
  - Consequence: an input held high through reset produces a rising edge once it has been debounced.
- Reset mid-debounce discards the partial count.

## Timing
- pio_in changes before edge k:
  - sync2 updates at k+1.
  - stable / DATA updates at k+1+DEBOUNCE_CYCLES.
  - EDGE_CAPTURE sets at k+2+DEBOUNCE_CYCLES.
  - irq asserts at k+3+DEBOUNCE_CYCLES.
- Clearing the last masked capture bit at edge j deasserts irq at j+1.
- Writing IRQ_MASK affects irq one cycle after the write edge.
- Read latency is fixed at 1; there is no waitrequest.

## Configuration
- PIO_DEBOUNCE_EN defined: the debounce filter is compiled in as described above.
- PIO_DEBOUNCE_EN undefined: counters are removed and stable = sync2. DEBOUNCE_CYCLES is ignored. Latency becomes DATA at k+2, capture at k+3, irq at k+4.

## Structure
- Package pio_pkg holds:
  - register address localparams: REG_DATA=0, REG_IRQ_MASK=1, REG_EDGE_CAP=2, REG_EDGE_POL=3;
  - the data bus width constant, 32.
- Sub-module pio_debounce_ch covers one channel: synchroniser, counter and stable flop, with the same parameter and macro. It is generated WIDTH times.
- The top level holds the register file, edge logic, irq and readdata.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, macro defined.
- Reset with pio_in=0. Read all registers → all 0, irq=0.
- Set pio_in[0]=1 and hold; IRQ_MASK=1 → DATA=0x1 at edge k+5, EDGE_CAPTURE=0x1 at k+6, irq=1 at k+7.
- Pulse pio_in[1] high for 3 cycles → DATA and EDGE_CAPTURE remain 0.
- Write EDGE_POL=0x4, drive pio_in[2] 1 then 0 (each held 10 cycles) → capture bit 2 sets only after the fall.
- Write EDGE_CAPTURE=0x1 in the same cycle a new bit-0 edge fires → bit 0 stays 1 and irq stays 1.
- Rebuild without PIO_DEBOUNCE_EN and drive a 1-cycle pulse on pio_in[3] → DATA[3] shows the pulse at edge k+2 and EDGE_CAPTURE[3]=1.
